// File: rtl/axi4_l1_snoop_cache.sv
// -----------------------------------------------------------------------------
// axi4_l1_snoop_cache
//
// Per-master L1 cache placed between one AXI4 master ("in") and one AXI4
// interconnect port ("out"). It is fully associative, holds one data word per
// line, and replaces lines round-robin. Single-beat, full-width reads are
// looked up and allocated on a miss. Every other read is forwarded without
// lookup or allocation. Writes are write-through and never allocate.
//
// Instances are used in pairs. Each one broadcasts the address of every local
// write on o_snoop_addr. The peer invalidates its own copy of that line.
//
// Ports
//   clk_i, rst_n             clock (rising edge), async active-low reset
//   in_ar*/in_r*             upstream read address / read data (slave side)
//   in_aw*/in_w*/in_b*       upstream write address / data / response
//   out_ar*/out_r*           downstream read address / read data (master side)
//   out_aw*/out_w*/out_b*    downstream write address / data / response
//   i_snoop_addr(_valid)     invalidate request from the peer cache
//   o_snoop_stall            this cache cannot take a snoop this cycle
//   o_snoop_addr(_valid)     broadcast of the buffered local write address
//   i_snoop_stall            the peer's o_snoop_stall
// -----------------------------------------------------------------------------
module axi4_l1_snoop_cache #(
    parameter int CACHE_WAYS         = 4,
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    // upstream read
    input  logic [AXI4_ID_WIDTH-1:0]      in_arid_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] in_araddr_i,
    input  logic [7:0]                    in_arlen_i,
    input  logic [2:0]                    in_arsize_i,
    input  logic [1:0]                    in_arburst_i,
    input  logic                          in_arvalid_i,
    output logic                          in_arready_o,
    output logic [AXI4_ID_WIDTH-1:0]      in_rid_o,
    output logic [AXI4_DATA_WIDTH-1:0]    in_rdata_o,
    output logic [1:0]                    in_rresp_o,
    output logic                          in_rlast_o,
    output logic                          in_rvalid_o,
    input  logic                          in_rready_i,
    // upstream write
    input  logic [AXI4_ID_WIDTH-1:0]      in_awid_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] in_awaddr_i,
    input  logic [7:0]                    in_awlen_i,
    input  logic [2:0]                    in_awsize_i,
    input  logic [1:0]                    in_awburst_i,
    input  logic                          in_awvalid_i,
    output logic                          in_awready_o,
    input  logic [AXI4_DATA_WIDTH-1:0]    in_wdata_i,
    input  logic [AXI4_DATA_WIDTH/8-1:0]  in_wstrb_i,
    input  logic                          in_wlast_i,
    input  logic                          in_wvalid_i,
    output logic                          in_wready_o,
    output logic [AXI4_ID_WIDTH-1:0]      in_bid_o,
    output logic [1:0]                    in_bresp_o,
    output logic                          in_bvalid_o,
    input  logic                          in_bready_i,
    // downstream read
    output logic [AXI4_ID_WIDTH-1:0]      out_arid_o,
    output logic [AXI4_ADDRESS_WIDTH-1:0] out_araddr_o,
    output logic [7:0]                    out_arlen_o,
    output logic [2:0]                    out_arsize_o,
    output logic [1:0]                    out_arburst_o,
    output logic                          out_arvalid_o,
    input  logic                          out_arready_i,
    input  logic [AXI4_ID_WIDTH-1:0]      out_rid_i,
    input  logic [AXI4_DATA_WIDTH-1:0]    out_rdata_i,
    input  logic [1:0]                    out_rresp_i,
    input  logic                          out_rlast_i,
    input  logic                          out_rvalid_i,
    output logic                          out_rready_o,
    // downstream write
    output logic [AXI4_ID_WIDTH-1:0]      out_awid_o,
    output logic [AXI4_ADDRESS_WIDTH-1:0] out_awaddr_o,
    output logic [7:0]                    out_awlen_o,
    output logic [2:0]                    out_awsize_o,
    output logic [1:0]                    out_awburst_o,
    output logic                          out_awvalid_o,
    input  logic                          out_awready_i,
    output logic [AXI4_DATA_WIDTH-1:0]    out_wdata_o,
    output logic [AXI4_DATA_WIDTH/8-1:0]  out_wstrb_o,
    output logic                          out_wlast_o,
    output logic                          out_wvalid_o,
    input  logic                          out_wready_i,
    input  logic [AXI4_ID_WIDTH-1:0]      out_bid_i,
    input  logic [1:0]                    out_bresp_i,
    input  logic                          out_bvalid_i,
    output logic                          out_bready_o,
    // snoop
    input  logic [AXI4_ADDRESS_WIDTH-1:0] i_snoop_addr,
    input  logic                          i_snoop_addr_valid,
    output logic                          o_snoop_stall,
    output logic [AXI4_ADDRESS_WIDTH-1:0] o_snoop_addr,
    output logic                          o_snoop_addr_valid,
    input  logic                          i_snoop_stall
);

    localparam int AW  = AXI4_ADDRESS_WIDTH;
    localparam int DW  = AXI4_DATA_WIDTH;
    localparam int IW  = AXI4_ID_WIDTH;
    localparam int OFF = $clog2(DW / 8);
    localparam int TW  = AW - OFF;
    localparam int PW  = (CACHE_WAYS > 1) ? $clog2(CACHE_WAYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HIT_RSP = 2'd1,
        S_MISS_AR = 2'd2,
        S_MISS_R  = 2'd3
    } rd_state_e;

    // Line tag: the address with the byte offset within the word dropped.
    function automatic logic [TW-1:0] line_of(input logic [AW-1:0] a);
        return TW'(a >> OFF);
    endfunction

    // ---------------- line array ----------------
    logic [CACHE_WAYS-1:0] line_vld_q, line_vld_d;
    logic [TW-1:0]         line_tag_q [CACHE_WAYS];
    logic [DW-1:0]         line_dat_q [CACHE_WAYS];
    logic [PW-1:0]         rr_q, rr_d;

    // ---------------- read path state ----------------
    rd_state_e     state_q, state_d;
    logic [IW-1:0] ar_id_q;
    logic [AW-1:0] ar_addr_q;
    logic [7:0]    ar_len_q;
    logic [2:0]    ar_size_q;
    logic [1:0]    ar_burst_q;
    logic          ar_cacheable_q;
    logic [DW-1:0] hit_data_q;
    logic          kill_q, kill_d;

    // ---------------- write address buffer ----------------
    logic          aw_full_q, aw_full_d;
    logic          bcast_done_q, bcast_done_d;
    logic [IW-1:0] aw_id_q;
    logic [AW-1:0] aw_addr_q;
    logic [7:0]    aw_len_q;
    logic [2:0]    aw_size_q;
    logic [1:0]    aw_burst_q;

    logic          ar_hs, ar_cacheable, hit;
    logic [DW-1:0] hit_data;
    logic          aw_acc, snoop_acc, fill_en;
    logic          aw_hits_miss;

    assign ar_hs        = (state_q == S_IDLE) && in_arvalid_i;
    assign ar_cacheable = (in_arlen_i == 8'd0) && (in_arsize_i == 3'(OFF));
    assign aw_acc       = in_awvalid_i && !aw_full_q;
    assign aw_hits_miss = aw_acc && (line_of(in_awaddr_i) == line_of(ar_addr_q));

    // A fill that coincides with a matching local AW acceptance is dropped,
    // otherwise the line would be refilled with the pre-write data.
    assign fill_en = (state_q == S_MISS_R) && out_rvalid_i && in_rready_i &&
                     ar_cacheable_q && (out_rresp_i == 2'b00) &&
                     !kill_q && !aw_hits_miss;

    // The line array has one write port; a snoop waits out a fill cycle.
    assign snoop_acc     = i_snoop_addr_valid && !fill_en;
    assign o_snoop_stall = fill_en;

    // Lookup of the incoming AR address (tags are unique among valid lines).
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < CACHE_WAYS; i++) begin
            if (line_vld_q[i] && (line_tag_q[i] == line_of(in_araddr_i))) begin
                hit      = 1'b1;
                hit_data = line_dat_q[i];
            end
        end
    end

    // Invalidations first, then the fill, which only targets the rr way.
    always_comb begin
        line_vld_d = line_vld_q;
        for (int i = 0; i < CACHE_WAYS; i++) begin
            if (snoop_acc && (line_tag_q[i] == line_of(i_snoop_addr))) begin
                line_vld_d[i] = 1'b0;
            end
            if (aw_acc && (line_tag_q[i] == line_of(in_awaddr_i))) begin
                line_vld_d[i] = 1'b0;
            end
        end
        if (fill_en) begin
            line_vld_d[rr_q] = 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (fill_en) begin
            rr_d = (rr_q == PW'(CACHE_WAYS - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    // The kill flag covers the AR handshake cycle and the outstanding miss.
    always_comb begin
        kill_d = kill_q;
        if (ar_hs) begin
            kill_d = (snoop_acc && (line_of(i_snoop_addr) == line_of(in_araddr_i))) ||
                     (aw_acc && (line_of(in_awaddr_i) == line_of(in_araddr_i)));
        end else if ((state_q == S_MISS_AR) || (state_q == S_MISS_R)) begin
            if ((snoop_acc && (line_of(i_snoop_addr) == line_of(ar_addr_q))) || aw_hits_miss) begin
                kill_d = 1'b1;
            end
        end
    end

    // Broadcast must finish before the AW is released downstream.
    always_comb begin
        aw_full_d    = aw_full_q;
        bcast_done_d = bcast_done_q;
        if (aw_acc) begin
            aw_full_d    = 1'b1;
            bcast_done_d = 1'b0;
        end else if (aw_full_q) begin
            if (!bcast_done_q && !i_snoop_stall) begin
                bcast_done_d = 1'b1;
            end
            if (bcast_done_q && out_awready_i) begin
                aw_full_d = 1'b0;
            end
        end
    end

    // ---------------- read FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            line_vld_q   <= '0;
            rr_q         <= '0;
            kill_q       <= 1'b0;
            aw_full_q    <= 1'b0;
            bcast_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_vld_q   <= line_vld_d;
            rr_q         <= rr_d;
            kill_q       <= kill_d;
            aw_full_q    <= aw_full_d;
            bcast_done_q <= bcast_done_d;
        end
    end

    // Payload registers carry no reset; their valid flags qualify them.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            line_tag_q[rr_q] <= line_of(ar_addr_q);
            line_dat_q[rr_q] <= out_rdata_i;
        end
        if (ar_hs) begin
            ar_id_q        <= in_arid_i;
            ar_addr_q      <= in_araddr_i;
            ar_len_q       <= in_arlen_i;
            ar_size_q      <= in_arsize_i;
            ar_burst_q     <= in_arburst_i;
            ar_cacheable_q <= ar_cacheable;
            hit_data_q     <= hit_data;
        end
        if (aw_acc) begin
            aw_id_q    <= in_awid_i;
            aw_addr_q  <= in_awaddr_i;
            aw_len_q   <= in_awlen_i;
            aw_size_q  <= in_awsize_i;
            aw_burst_q <= in_awburst_i;
        end
    end

    // ---------------- read FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_arvalid_i) state_d = (ar_cacheable && hit) ? S_HIT_RSP : S_MISS_AR;
            S_HIT_RSP: if (in_rready_i) state_d = S_IDLE;
            S_MISS_AR: if (out_arready_i) state_d = S_MISS_R;
            S_MISS_R:  if (out_rvalid_i && in_rready_i && out_rlast_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- read FSM: outputs ----------------
    always_comb begin
        in_arready_o  = (state_q == S_IDLE);
        out_arvalid_o = (state_q == S_MISS_AR);
        out_arid_o    = ar_id_q;
        out_araddr_o  = ar_addr_q;
        out_arlen_o   = ar_len_q;
        out_arsize_o  = ar_size_q;
        out_arburst_o = ar_burst_q;
        in_rvalid_o   = 1'b0;
        in_rid_o      = ar_id_q;
        in_rdata_o    = hit_data_q;
        in_rresp_o    = 2'b00;
        in_rlast_o    = 1'b1;
        out_rready_o  = 1'b0;
        case (state_q)
            S_HIT_RSP: in_rvalid_o = 1'b1;
            S_MISS_R: begin
                in_rvalid_o  = out_rvalid_i;
                in_rid_o     = out_rid_i;
                in_rdata_o   = out_rdata_i;
                in_rresp_o   = out_rresp_i;
                in_rlast_o   = out_rlast_i;
                out_rready_o = in_rready_i;
            end
            default: ;
        endcase
    end

    // ---------------- write path ----------------
    assign in_awready_o       = !aw_full_q;
    assign o_snoop_addr       = aw_addr_q;
    assign o_snoop_addr_valid = aw_full_q && !bcast_done_q;
    assign out_awvalid_o      = aw_full_q && bcast_done_q;
    assign out_awid_o         = aw_id_q;
    assign out_awaddr_o       = aw_addr_q;
    assign out_awlen_o        = aw_len_q;
    assign out_awsize_o       = aw_size_q;
    assign out_awburst_o      = aw_burst_q;

    // W and B are pure pass-through; valids are held low while in reset.
    assign out_wvalid_o = in_wvalid_i && rst_n;
    assign out_wdata_o  = in_wdata_i;
    assign out_wstrb_o  = in_wstrb_i;
    assign out_wlast_o  = in_wlast_i;
    assign in_wready_o  = out_wready_i;
    assign in_bvalid_o  = out_bvalid_i && rst_n;
    assign in_bid_o     = out_bid_i;
    assign in_bresp_o   = out_bresp_i;
    assign out_bready_o = in_bready_i;

endmodule

// File: tb/tb_axi4_l1_snoop_cache.sv
module tb_axi4_l1_snoop_cache;

    localparam int CW = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [IW-1:0] in_arid, in_rid, in_awid, in_bid, out_arid, out_rid, out_awid, out_bid;
    logic [AW-1:0] in_araddr, in_awaddr, out_araddr, out_awaddr;
    logic [7:0]    in_arlen, in_awlen, out_arlen, out_awlen;
    logic [2:0]    in_arsize, in_awsize, out_arsize, out_awsize;
    logic [1:0]    in_arburst, in_awburst, out_arburst, out_awburst;
    logic          in_arvalid, in_arready, in_rvalid, in_rready, in_rlast;
    logic [DW-1:0] in_rdata, in_wdata, out_rdata, out_wdata;
    logic [1:0]    in_rresp, in_bresp, out_rresp, out_bresp;
    logic          in_awvalid, in_awready, in_wvalid, in_wready, in_wlast, in_bvalid, in_bready;
    logic [DW/8-1:0] in_wstrb, out_wstrb;
    logic          out_arvalid, out_arready, out_rvalid, out_rready, out_rlast;
    logic          out_awvalid, out_awready, out_wvalid, out_wready, out_wlast, out_bvalid, out_bready;
    logic [AW-1:0] i_snoop_addr, o_snoop_addr;
    logic          i_snoop_addr_valid, o_snoop_stall, o_snoop_addr_valid, i_snoop_stall;

    axi4_l1_snoop_cache #(
        .CACHE_WAYS(CW), .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)
    ) dut (
        .clk_i(clk), .rst_n(rst_n),
        .in_arid_i(in_arid), .in_araddr_i(in_araddr), .in_arlen_i(in_arlen), .in_arsize_i(in_arsize),
        .in_arburst_i(in_arburst), .in_arvalid_i(in_arvalid), .in_arready_o(in_arready),
        .in_rid_o(in_rid), .in_rdata_o(in_rdata), .in_rresp_o(in_rresp), .in_rlast_o(in_rlast),
        .in_rvalid_o(in_rvalid), .in_rready_i(in_rready),
        .in_awid_i(in_awid), .in_awaddr_i(in_awaddr), .in_awlen_i(in_awlen), .in_awsize_i(in_awsize),
        .in_awburst_i(in_awburst), .in_awvalid_i(in_awvalid), .in_awready_o(in_awready),
        .in_wdata_i(in_wdata), .in_wstrb_i(in_wstrb), .in_wlast_i(in_wlast), .in_wvalid_i(in_wvalid),
        .in_wready_o(in_wready), .in_bid_o(in_bid), .in_bresp_o(in_bresp), .in_bvalid_o(in_bvalid),
        .in_bready_i(in_bready),
        .out_arid_o(out_arid), .out_araddr_o(out_araddr), .out_arlen_o(out_arlen), .out_arsize_o(out_arsize),
        .out_arburst_o(out_arburst), .out_arvalid_o(out_arvalid), .out_arready_i(out_arready),
        .out_rid_i(out_rid), .out_rdata_i(out_rdata), .out_rresp_i(out_rresp), .out_rlast_i(out_rlast),
        .out_rvalid_i(out_rvalid), .out_rready_o(out_rready),
        .out_awid_o(out_awid), .out_awaddr_o(out_awaddr), .out_awlen_o(out_awlen), .out_awsize_o(out_awsize),
        .out_awburst_o(out_awburst), .out_awvalid_o(out_awvalid), .out_awready_i(out_awready),
        .out_wdata_o(out_wdata), .out_wstrb_o(out_wstrb), .out_wlast_o(out_wlast), .out_wvalid_o(out_wvalid),
        .out_wready_i(out_wready), .out_bid_i(out_bid), .out_bresp_i(out_bresp), .out_bvalid_i(out_bvalid),
        .out_bready_o(out_bready),
        .i_snoop_addr(i_snoop_addr), .i_snoop_addr_valid(i_snoop_addr_valid), .o_snoop_stall(o_snoop_stall),
        .o_snoop_addr(o_snoop_addr), .o_snoop_addr_valid(o_snoop_addr_valid), .i_snoop_stall(i_snoop_stall)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: which word-lines are resident, plus downstream memory.
    int           m_line [CW];
    bit           m_val  [CW];
    int           m_ptr;
    logic [31:0]  mem [int];

    function automatic logic [31:0] memrd(input int ln);
        if (mem.exists(ln)) return mem[ln];
        return 32'hC0DE_0000 ^ 32'(ln);
    endfunction

    function automatic bit m_hit(input int ln);
        for (int i = 0; i < CW; i++) if (m_val[i] && m_line[i] == ln) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_inval(input int ln);
        for (int i = 0; i < CW; i++) if (m_line[i] == ln) m_val[i] = 1'b0;
    endfunction

    function automatic void m_fill(input int ln);
        m_line[m_ptr] = ln;
        m_val[m_ptr]  = 1'b1;
        m_ptr         = (m_ptr + 1) % CW;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < CW; i++) begin m_val[i] = 1'b0; m_line[i] = -1; end
        m_ptr = 0;
    endfunction

    // One read on "in", acting as the downstream slave when it misses.
    task automatic rd(input logic [31:0] a, input int len, input bit err, input bit snp_mid, input bit snp_fill);
        int ln = int'(a >> 2);
        bit cach = (len == 0);
        bit exp_hit = cach && m_hit(ln);
        bit exp_fill = cach && !exp_hit && !err && !snp_mid;
        logic [IW-1:0] id = IW'($urandom);
        @(negedge clk);
        in_arvalid = 1'b1; in_araddr = a; in_arlen = 8'(len); in_arsize = 3'd2; in_arburst = 2'b01; in_arid = id;
        #1 chk("ar_ready", in_arready, 1);
        @(negedge clk);
        in_arvalid = 1'b0;
        #1;
        if (exp_hit) begin
            chk("hit_rvalid", in_rvalid, 1);
            chk("hit_rdata", in_rdata, memrd(ln));
            chk("hit_rid", in_rid, id);
            chk("hit_rlast", in_rlast, 1);
            chk("hit_rresp", in_rresp, 0);
            chk("hit_no_out_ar", out_arvalid, 0);
            @(negedge clk);
            #1 chk("hit_done", in_rvalid, 0);
        end else begin
            chk("miss_out_ar", out_arvalid, 1);
            chk("miss_araddr", out_araddr, a);
            chk("miss_arlen", out_arlen, len);
            chk("miss_arsize", out_arsize, 2);
            chk("miss_arburst", out_arburst, 1);
            chk("miss_arid", out_arid, id);
            chk("miss_no_early_r", in_rvalid, 0);
            out_arready = 1'b1;
            if (snp_mid) begin i_snoop_addr = a; i_snoop_addr_valid = 1'b1; end
            @(negedge clk);
            out_arready = 1'b0; i_snoop_addr_valid = 1'b0;
            for (int b = 0; b <= len; b++) begin
                out_rvalid = 1'b1; out_rid = id; out_rdata = memrd(ln + b);
                out_rresp = err ? 2'b10 : 2'b00; out_rlast = (b == len);
                if (snp_fill && b == len) begin i_snoop_addr = a; i_snoop_addr_valid = 1'b1; end
                #1;
                chk("r_valid", in_rvalid, 1);
                chk("r_data", in_rdata, memrd(ln + b));
                chk("r_last", in_rlast, (b == len));
                chk("r_resp", in_rresp, err ? 2 : 0);
                chk("r_id", in_rid, id);
                chk("r_ready_fwd", out_rready, 1);
                chk("fill_snoop_stall", o_snoop_stall, exp_fill && (b == len));
                chk("r_ar_dropped", out_arvalid, 0);
                @(negedge clk);
            end
            out_rvalid = 1'b0; out_rlast = 1'b0;
            #1 chk("miss_done", in_rvalid, 0);
            if (exp_fill) m_fill(ln);
            if (snp_fill) begin
                chk("snoop_retry_accepted", o_snoop_stall, 0);
                m_inval(ln);
                @(negedge clk);
                i_snoop_addr_valid = 1'b0;
            end
        end
    endtask

    // One-cycle snoop from the peer; newdata models the peer's write landing.
    task automatic snoop(input logic [31:0] a, input bit newdata);
        @(negedge clk);
        i_snoop_addr = a; i_snoop_addr_valid = 1'b1;
        #1 chk("snoop_stall_idle", o_snoop_stall, 0);
        m_inval(int'(a >> 2));
        if (newdata) mem[int'(a >> 2)] = $urandom;
        @(negedge clk);
        i_snoop_addr_valid = 1'b0;
    endtask

    // Single-beat local write; the peer stalls the broadcast for st cycles.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int st);
        logic [IW-1:0] id = IW'($urandom);
        @(negedge clk);
        in_awvalid = 1'b1; in_awaddr = a; in_awid = id; in_awlen = 8'd0; in_awsize = 3'd2; in_awburst = 2'b01;
        #1 chk("aw_ready", in_awready, 1);
        m_inval(int'(a >> 2));
        for (int k = 0; k <= st; k++) begin
            @(negedge clk);
            in_awvalid = 1'b0; i_snoop_stall = (k < st);
            #1;
            chk("bcast_valid", o_snoop_addr_valid, 1);
            chk("bcast_addr", o_snoop_addr, a);
            chk("aw_held_back", out_awvalid, 0);
            chk("aw_buf_busy", in_awready, 0);
        end
        @(negedge clk);
        i_snoop_stall = 1'b0;
        #1;
        chk("bcast_over", o_snoop_addr_valid, 0);
        chk("out_awvalid", out_awvalid, 1);
        chk("out_awaddr", out_awaddr, a);
        chk("out_awid", out_awid, id);
        chk("out_awlen", out_awlen, 0);
        chk("out_awsize", out_awsize, 2);
        chk("out_awburst", out_awburst, 1);
        out_awready = 1'b1;
        @(negedge clk);
        out_awready = 1'b0;
        #1;
        chk("aw_buf_free", in_awready, 1);
        chk("aw_gone", out_awvalid, 0);
        in_wvalid = 1'b1; in_wdata = d; in_wstrb = '1; in_wlast = 1'b1; out_wready = 1'b1;
        #1;
        chk("w_valid", out_wvalid, 1);
        chk("w_data", out_wdata, d);
        chk("w_strb", out_wstrb, 4'hF);
        chk("w_last", out_wlast, 1);
        chk("w_ready", in_wready, 1);
        @(negedge clk);
        in_wvalid = 1'b0; out_wready = 1'b0;
        mem[int'(a >> 2)] = d;
        out_bvalid = 1'b1; out_bid = id; out_bresp = 2'b00; in_bready = 1'b1;
        #1;
        chk("b_valid", in_bvalid, 1);
        chk("b_id", in_bid, id);
        chk("b_resp", in_bresp, 0);
        chk("b_ready", out_bready, 1);
        @(negedge clk);
        out_bvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        in_arid = '0; in_araddr = '0; in_arlen = '0; in_arsize = 3'd2; in_arburst = 2'b01; in_arvalid = 1'b0;
        in_rready = 1'b1;
        in_awid = '0; in_awaddr = '0; in_awlen = '0; in_awsize = 3'd2; in_awburst = 2'b01; in_awvalid = 1'b0;
        in_wdata = '0; in_wstrb = '0; in_wlast = 1'b0; in_bready = 1'b1;
        out_arready = 1'b0; out_rid = '0; out_rdata = '0; out_rresp = '0; out_rlast = 1'b0; out_rvalid = 1'b0;
        out_awready = 1'b0; out_wready = 1'b0; out_bid = '0; out_bresp = '0;
        i_snoop_addr = '0; i_snoop_addr_valid = 1'b0; i_snoop_stall = 1'b0;
        m_reset();
        mem[int'(32'h100 >> 2)] = 32'hA5A5_0001;

        // Reset: W/B valids driven high upstream must not leak through.
        rst_n = 1'b1;
        in_wvalid = 1'b1; out_bvalid = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_rvalid", in_rvalid, 0);
        chk("rst_in_bvalid", in_bvalid, 0);
        chk("rst_out_arvalid", out_arvalid, 0);
        chk("rst_out_awvalid", out_awvalid, 0);
        chk("rst_out_wvalid", out_wvalid, 0);
        chk("rst_snoop_valid", o_snoop_addr_valid, 0);
        chk("rst_snoop_stall", o_snoop_stall, 0);
        in_wvalid = 1'b0; out_bvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Miss then hit on 0x100.
        rd(32'h100, 0, 0, 0, 0);
        rd(32'h100, 0, 0, 0, 0);
        // Same line, different byte offset, still hits.
        rd(32'h102, 0, 0, 0, 0);
        // Peer snoop, then miss.
        snoop(32'h100, 0);
        rd(32'h100, 0, 0, 0, 0);
        // Local write with 3 stall cycles, then miss with new data.
        wr(32'h100, 32'h1234_5678, 3);
        rd(32'h100, 0, 0, 0, 0);
        // Five distinct lines into four ways: first evicted.
        for (int i = 0; i < 5; i++) rd(32'h300 + 32'(4 * i), 0, 0, 0, 0);
        for (int i = 1; i < 5; i++) rd(32'h300 + 32'(4 * i), 0, 0, 0, 0);
        rd(32'h300, 0, 0, 0, 0);
        // Burst read is bypassed and never allocated.
        rd(32'h400, 3, 0, 0, 0);
        rd(32'h400, 3, 0, 0, 0);
        // Error response and mid-miss snoop both suppress allocation.
        rd(32'h500, 0, 1, 0, 0);
        rd(32'h500, 0, 0, 0, 0);
        rd(32'h600, 0, 0, 1, 0);
        rd(32'h600, 0, 0, 0, 0);
        // Snoop colliding with a fill is stalled, then invalidates.
        rd(32'h700, 0, 0, 0, 1);
        rd(32'h700, 0, 0, 0, 0);
        rd(32'h700, 0, 0, 0, 0);

        // Randomized mix over a small address pool.
        for (int it = 0; it < 60; it++) begin
            ra = 32'h200 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0, 1, 2: rd(ra, 0, ($urandom_range(0, 7) == 0), 0, 0);
                3:       snoop(ra, 1);
                4:       wr(ra, $urandom, $urandom_range(0, 2));
                5:       rd(ra, 0, 0, ($urandom_range(0, 1) == 1), 0);
                default: rd(ra & 32'hFFFF_FFFC, $urandom_range(1, 3), 0, 0, 0);
            endcase
        end

        // Reset while a miss is waiting on out.AR abandons it.
        @(negedge clk);
        in_arvalid = 1'b1; in_araddr = 32'h900; in_arlen = 8'd0; in_arsize = 3'd2; in_arid = 4'h3;
        @(negedge clk);
        in_arvalid = 1'b0;
        #1 chk("pre_rst_out_ar", out_arvalid, 1);
        rst_n = 1'b0;
        #1 chk("rst_abandon_ar", out_arvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        rd(32'h100, 0, 0, 0, 0);
        rd(32'h100, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_l1_snoop_cache.md
Name: axi4_l1_snoop_cache

Overview:
- Per-master L1 cache between one AXI4 master (`in`) and an AXI4 interconnect port (`out`).
- Fully-associative, one word per line, CACHE_WAYS lines. Reads are allocated; writes are write-through and no-allocate.
- Used in pairs: each instance broadcasts its write addresses on the snoop-out port, and the peer invalidates its matching line.
- Instantiated twice by the 2-master L1 interconnect, with the snoop ports cross-connected.

Parameters:
- CACHE_WAYS, 4, number of lines (>=1). Replacement is round-robin.
- AXI4_ADDRESS_WIDTH, 32, address width of `in`, `out` and snoop addresses.
- AXI4_DATA_WIDTH, 32, data width (power of 2, >=8). One line = one data word.
- AXI4_ID_WIDTH, 4, ID width of `in` and `out`. IDs pass through unchanged.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in  axi4_if.slave  -  upstream master-facing AXI4 port.
- out  axi4_if.master  -  downstream AXI4 port to the interconnect.
- i_snoop_addr  in  AXI4_ADDRESS_WIDTH  invalidate address from the peer.
- i_snoop_addr_valid  in  1  peer snoop request.
- o_snoop_stall  out  1  this cache cannot accept i_snoop this cycle.
- o_snoop_addr  out  AXI4_ADDRESS_WIDTH  address of the local write being broadcast.
- o_snoop_addr_valid  out  1  broadcast request. Held until the peer does not stall.
- i_snoop_stall  in  1  peer stall (the peer's o_snoop_stall).

Behaviour:
- Line match uses ADDR[AW-1:log2(DW/8)]; low byte-offset bits are ignored.
- Reset: all lines invalid; round-robin pointer = 0; read FSM = IDLE.
  - All VALID outputs are 0: in.R, in.B, out.AR, out.AW, out.W, o_snoop_addr_valid.
  - o_snoop_stall = 0.
  - Reset mid-transaction abandons it with no further beats.
- Read FSM: IDLE -> (HIT_RSP | MISS_AR) -> (MISS_R) -> IDLE.
  - in.ARREADY = 1 only in IDLE. The AR fields are captured on the handshake.
  - Cacheable read: ARLEN == 0 and ARSIZE == log2(DW/8). Any other read is a bypass: never looked up, never allocated.
  - Cacheable hit -> HIT_RSP on the next cycle: in.RVALID = 1, RDATA = line data, RID = captured ID, RRESP = 0, RLAST = 1.
    - Hold until RREADY, then IDLE.
    - No out traffic.
  - Miss or bypass -> MISS_AR: out.AR is driven with the captured fields until out.ARREADY.
  - MISS_R: out.R is forwarded combinationally to in.R, and in.RREADY is forwarded to out.RREADY.
    - Return to IDLE on the beat with RLAST.
  - Fill: cacheable miss, beat accepted, RRESP == 0 and not killed -> write the line at the round-robin pointer, then increment the pointer mod CACHE_WAYS.
  - Kill: the fill is suppressed if a snoop or a local write to the same address is accepted while the miss is outstanding.
- Write path (AW/W/B):
  - W and B pass through combinationally.
  - AW is held in a one-entry buffer. in.AWREADY = 1 when the buffer is empty.
  - Once buffered: o_snoop_addr = AWADDR and o_snoop_addr_valid = 1.
  - The broadcast completes on the first cycle with i_snoop_stall = 0. out.AWVALID is asserted only after it completes.
  - The buffer empties on the out.AW handshake.
  - A local write invalidates the matching local line when its AW is accepted.
- Snoop in:
  - o_snoop_stall = 1 only in a cycle where a fill writes the line array.
  - i_snoop_addr_valid with o_snoop_stall = 0 invalidates a matching valid line on the next edge. A miss is a no-op.
  - A stalled peer holds its request, so it is retried.
- Snoop and local-write invalidates of the same line in the same cycle: the line is invalid.
- Reads and writes are independent. No ordering is enforced between a cached read and an outstanding write, except by invalidation.

Test Plan:
- Reset, then a cacheable read of 0x100 (downstream returns 0xA5A5_0001) -> one out AR. in.R gets that data with RLAST=1.
  - Repeat the read -> no out AR. RVALID one cycle after the AR handshake with 0xA5A5_0001.
- Peer snoop 0x100 (i_snoop_addr_valid, 1 cycle), then read 0x100 -> miss: out AR issued.
- Local write to 0x100 with i_snoop_stall = 1 for 3 cycles:
  - o_snoop_addr = 0x100 is held 4 cycles.
  - out.AWVALID rises only after the stall drops.
  - A following read of 0x100 misses.
- Fill 5 distinct addresses with CACHE_WAYS = 4 -> the first address is evicted (read misses) and the other 4 hit.
- Read with ARLEN = 3 -> 4 beats forwarded; a repeat read still goes to out (not allocated).
- Cacheable miss with RRESP = SLVERR, or a snoop to the same address during the miss -> no allocation; the next read misses.
- Snoop in the cycle of a fill completion -> o_snoop_stall = 1. The held snoop invalidates next cycle; a read of that address misses.
